systolic_tile_scheduler: RTL and testbench

Sequences the 4x4 systolic core across matrices larger than one tile, computing C[M x N] = A[M x K] * B[K x N] with M, N and K given as multiples of the tile size T. For each output tile it reads A and B tiles from word-addressed operand memories and packs them into the core's flat input buses. It pulses the core's start and accumulates the per-K-tile results into a partial-sum bank, then writes the finished C tile row by row to the result memory. It sits between the buffer/memory subsystem and the systolic core instance.

---
 rtl/systolic_tile_scheduler.sv | 247 ++++++++++++++++++++++++
 tb/tb_systolic_tile_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_scheduler.sv
// Tile scheduler for a TxT systolic core: walks the M/N/K tile loops, gathers operand
// tiles from word memories, accumulates per-K partial sums and streams C tile rows out.
module systolic_tile_scheduler #(
  parameter int AW    = 8,
  parameter int BW    = 8,
  parameter int ACCW  = 32,
  parameter int T     = 4,
  parameter int DIMW  = 8,
  parameter int ADDRW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DIMW-1:0]       cfg_m_tiles,
  input  logic [DIMW-1:0]       cfg_n_tiles,
  input  logic [DIMW-1:0]       cfg_k_tiles,
  output logic                  a_rd_en,
  output logic [ADDRW-1:0]      a_rd_addr,
  input  logic [T*AW-1:0]       a_rd_data,
  output logic                  b_rd_en,
  output logic [ADDRW-1:0]      b_rd_addr,
  input  logic [T*BW-1:0]       b_rd_data,
  output logic                  core_start,
  output logic [T*T*AW-1:0]     core_A,
  output logic [T*T*BW-1:0]     core_B,
  input  logic                  core_done,
  input  logic [T*T*ACCW-1:0]   core_C,
  output logic                  c_wr_en,
  output logic [ADDRW-1:0]      c_wr_addr,
  output logic [T*ACCW-1:0]     c_wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int SW = $clog2(T + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_ACCUM, S_WRITE, S_FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          sub_q, sub_d;
  logic [DIMW-1:0]        m_q, m_d, n_q, n_d, k_q, k_d;
  logic [DIMW-1:0]        mt_q, mt_d, nt_q, nt_d, kt_q, kt_d;
  logic [ADDRW-1:0]       a_mbase_q, a_mbase_d, a_rowp_q, a_rowp_d;
  logic [ADDRW-1:0]       b_kbase_q, b_kbase_d, b_rowp_q, b_rowp_d;
  logic [ADDRW-1:0]       c_mbase_q, c_mbase_d, c_rowp_q, c_rowp_d;
  logic [T*T*AW-1:0]      a_tile_q, a_tile_d;
  logic [T*T*BW-1:0]      b_tile_q, b_tile_d;
  logic [T*T*ACCW-1:0]    p_q, p_d;
  logic [ADDRW-1:0]       a_row, b_row, c_row;

  assign core_A    = a_tile_q;
  assign core_B    = b_tile_q;
  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);

  // Row addresses are running sums (+k_tiles / +n_tiles per row). A full LOAD leaves
  // a_rowp at the next M-tile base and b_rowp at the next K-tile base, so those are reused.
  assign a_row = (sub_q == '0) ? a_mbase_q : a_rowp_q;
  assign b_row = (sub_q == '0) ? b_kbase_q : b_rowp_q;
  assign c_row = (sub_q == '0) ? c_mbase_q : c_rowp_q;

  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    m_d        = m_q;
    n_d        = n_q;
    k_d        = k_q;
    mt_d       = mt_q;
    nt_d       = nt_q;
    kt_d       = kt_q;
    a_mbase_d  = a_mbase_q;
    a_rowp_d   = a_rowp_q;
    b_kbase_d  = b_kbase_q;
    b_rowp_d   = b_rowp_q;
    c_mbase_d  = c_mbase_q;
    c_rowp_d   = c_rowp_q;
    a_tile_d   = a_tile_q;
    b_tile_d   = b_tile_q;
    p_d        = p_q;
    a_rd_en    = 1'b0;
    a_rd_addr  = '0;
    b_rd_en    = 1'b0;
    b_rd_addr  = '0;
    core_start = 1'b0;
    c_wr_en    = 1'b0;
    c_wr_addr  = '0;
    c_wr_data  = '0;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          m_d       = cfg_m_tiles;
          n_d       = cfg_n_tiles;
          k_d       = cfg_k_tiles;
          mt_d      = '0;
          nt_d      = '0;
          kt_d      = '0;
          sub_d     = '0;
          a_mbase_d = '0;
          b_kbase_d = '0;
          c_mbase_d = '0;
          if (cfg_m_tiles == '0 || cfg_n_tiles == '0 || cfg_k_tiles == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (sub_q < SW'(T)) begin
          a_rd_en   = 1'b1;
          b_rd_en   = 1'b1;
          a_rd_addr = a_row + ADDRW'(kt_q);
          b_rd_addr = b_row + ADDRW'(nt_q);
          a_rowp_d  = a_row + ADDRW'(k_q);
          b_rowp_d  = b_row + ADDRW'(n_q);
        end
        for (int unsigned i = 0; i < T; i++) begin
          if (sub_q == SW'(i + 1)) begin
            a_tile_d[i*T*AW +: T*AW] = a_rd_data;
            b_tile_d[i*T*BW +: T*BW] = b_rd_data;
          end
        end
        if (sub_q == SW'(T)) begin
          sub_d   = '0;
          state_d = S_START;
        end else begin
          sub_d = sub_q + SW'(1);
        end
      end

      S_START: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end

      // Partial sums are folded in on the core_done cycle itself; ACCUM only advances loops.
      S_WAIT: begin
        if (core_done) begin
          for (int unsigned e = 0; e < T*T; e++) begin
            if (kt_q == '0) begin
              p_d[e*ACCW +: ACCW] = core_C[e*ACCW +: ACCW];
            end else begin
              p_d[e*ACCW +: ACCW] = p_q[e*ACCW +: ACCW] + core_C[e*ACCW +: ACCW];
            end
          end
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        sub_d = '0;
        if (kt_q == k_q - DIMW'(1)) begin
          state_d = S_WRITE;
        end else begin
          kt_d      = kt_q + DIMW'(1);
          b_kbase_d = b_rowp_q;
          state_d   = S_LOAD;
        end
      end

      S_WRITE: begin
        c_wr_en   = 1'b1;
        c_wr_addr = c_row + ADDRW'(nt_q);
        c_rowp_d  = c_row + ADDRW'(n_q);
        for (int unsigned i = 0; i < T; i++) begin
          if (sub_q == SW'(i)) begin
            c_wr_data = p_q[i*T*ACCW +: T*ACCW];
          end
        end
        if (sub_q == SW'(T - 1)) begin
          sub_d     = '0;
          kt_d      = '0;
          b_kbase_d = '0;
          state_d   = S_LOAD;
          if (nt_q == n_q - DIMW'(1)) begin
            nt_d      = '0;
            mt_d      = mt_q + DIMW'(1);
            a_mbase_d = a_rowp_q;
            c_mbase_d = c_row + ADDRW'(n_q);
            if (mt_q == m_q - DIMW'(1)) begin
              state_d = S_FINISH;
            end
          end else begin
            nt_d = nt_q + DIMW'(1);
          end
        end else begin
          sub_d = sub_q + SW'(1);
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sub_q     <= '0;
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      mt_q      <= '0;
      nt_q      <= '0;
      kt_q      <= '0;
      a_mbase_q <= '0;
      a_rowp_q  <= '0;
      b_kbase_q <= '0;
      b_rowp_q  <= '0;
      c_mbase_q <= '0;
      c_rowp_q  <= '0;
      a_tile_q  <= '0;
      b_tile_q  <= '0;
      p_q       <= '0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      m_q       <= m_d;
      n_q       <= n_d;
      k_q       <= k_d;
      mt_q      <= mt_d;
      nt_q      <= nt_d;
      kt_q      <= kt_d;
      a_mbase_q <= a_mbase_d;
      a_rowp_q  <= a_rowp_d;
      b_kbase_q <= b_kbase_d;
      b_rowp_q  <= b_rowp_d;
      c_mbase_q <= c_mbase_d;
      c_rowp_q  <= c_rowp_d;
      a_tile_q  <= a_tile_d;
      b_tile_q  <= b_tile_d;
      p_q       <= p_d;
    end
  end

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Bench for systolic_tile_scheduler: operand memories, a behavioural core, and a
// matrix-level model of the expected read/write streams checked every cycle.
module tb_systolic_tile_scheduler;
  localparam int AW = 8, BW = 8, ACCW = 32, T = 4, DIMW = 8, ADDRW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [DIMW-1:0]      cfg_m_tiles = '0, cfg_n_tiles = '0, cfg_k_tiles = '0;
  logic                 a_rd_en, b_rd_en, core_start, c_wr_en, busy, done;
  logic [ADDRW-1:0]     a_rd_addr, b_rd_addr, c_wr_addr;
  logic [T*AW-1:0]      a_rd_data = '0;
  logic [T*BW-1:0]      b_rd_data = '0;
  logic [T*T*AW-1:0]    core_A;
  logic [T*T*BW-1:0]    core_B;
  logic                 core_done;
  logic [T*T*ACCW-1:0]  core_C = '0;
  logic [T*ACCW-1:0]    c_wr_data;

  systolic_tile_scheduler #(.AW(AW), .BW(BW), .ACCW(ACCW), .T(T), .DIMW(DIMW), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles), .cfg_k_tiles(cfg_k_tiles),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .core_start(core_start), .core_A(core_A), .core_B(core_B),
    .core_done(core_done), .core_C(core_C),
    .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
    .busy(busy), .done(done)
  );

  // Matrices in element form; memory words are derived from them on each read.
  int Am[8][8];
  int Bm[8][8];
  int kcur = 1, ncur = 1;

  always @(posedge clk) begin
    if (a_rd_en && kcur != 0)
      for (int j = 0; j < T; j++)
        a_rd_data[j*AW +: AW] <= AW'(Am[int'(a_rd_addr) / kcur][(int'(a_rd_addr) % kcur)*T + j]);
    if (b_rd_en && ncur != 0)
      for (int j = 0; j < T; j++)
        b_rd_data[j*BW +: BW] <= BW'(Bm[int'(b_rd_addr) / ncur][(int'(b_rd_addr) % ncur)*T + j]);
  end

  // Behavioural core: fixed 3-cycle latency after start, or per-start stub constants.
  logic core_auto = 1'b1, stub_mode = 1'b0, man_done = 1'b0, auto_done_q = 1'b0;
  int stub_v[2];
  int stub_base = 0;
  int core_starts = 0;
  int cnt = 0;
  logic [T*T*ACCW-1:0] res_q = '0;
  assign core_done = auto_done_q | man_done;

  function automatic logic [T*T*ACCW-1:0] core_model(input logic [T*T*AW-1:0] a,
                                                      input logic [T*T*BW-1:0] b, input int idx);
    logic [T*T*ACCW-1:0] r;
    r = '0;
    for (int i = 0; i < T; i++)
      for (int c = 0; c < T; c++) begin
        int s;
        s = 0;
        if (stub_mode) s = (idx >= 0 && idx < 2) ? stub_v[idx] : 0;
        else
          for (int j = 0; j < T; j++)
            s += int'($signed(a[(i*T+j)*AW +: AW])) * int'($signed(b[(j*T+c)*BW +: BW]));
        r[(i*T+c)*ACCW +: ACCW] = s;
      end
    return r;
  endfunction

  always @(posedge clk) begin
    auto_done_q <= 1'b0;
    if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        auto_done_q <= 1'b1;
        core_C      <= res_q;
      end
    end
    if (core_start) begin
      core_starts <= core_starts + 1;
      if (core_auto) begin
        res_q <= core_model(core_A, core_B, core_starts - stub_base);
        cnt   <= 3;
      end
    end
  end

  // Expected streams (appended by the stimulus process, consumed by the monitor).
  int exp_a[$], exp_b[$], exp_ca[$];
  logic [T*ACCW-1:0] exp_cd[$];
  int log_a[$], log_ca[$];
  logic [T*ACCW-1:0] log_cd[$];

  function automatic void build_expect(input int m, input int n, input int k, input bit reads_only);
    for (int mt = 0; mt < m; mt++)
      for (int nt = 0; nt < n; nt++) begin
        for (int kt = 0; kt < k; kt++)
          for (int i = 0; i < T; i++) begin
            exp_a.push_back((mt*T + i)*k + kt);
            exp_b.push_back((kt*T + i)*n + nt);
          end
        if (!reads_only)
          for (int r = 0; r < T; r++) begin
            logic [T*ACCW-1:0] row;
            row = '0;
            for (int c = 0; c < T; c++) begin
              int s;
              s = 0;
              if (stub_mode) for (int kt = 0; kt < k; kt++) s += stub_v[kt];
              else for (int kk = 0; kk < k*T; kk++) s += Am[mt*T + r][kk] * Bm[kk][nt*T + c];
              row[c*ACCW +: ACCW] = s;
            end
            exp_ca.push_back((mt*T + r)*n + nt);
            exp_cd.push_back(row);
          end
      end
  endfunction

  int mon_pass = 0, mon_total = 0, tb_pass = 0, tb_total = 0;
  int a_ptr = 0, b_ptr = 0, c_ptr = 0, dones = 0, starts_seen = 0;
  logic mon_en = 1'b0, active_q = 1'b0;

  task automatic mcheck(input string nm, input logic [127:0] act, input logic [127:0] exp);
    mon_total++;
    if (act === exp) mon_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tcheck(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tb_total++;
    if (act === exp) tb_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic nxt;
      mcheck("busy", 128'(busy), 128'(active_q));
      mcheck("cfg_ready", 128'(cfg_ready), 128'(!active_q));
      if (a_rd_en) begin
        log_a.push_back(int'(a_rd_addr));
        if (a_ptr < exp_a.size()) begin
          mcheck("a_rd_addr", 128'(a_rd_addr), 128'(exp_a[a_ptr]));
          a_ptr++;
        end else mcheck("a_rd_extra", 128'(a_rd_en), 128'(0));
      end
      if (b_rd_en) begin
        if (b_ptr < exp_b.size()) begin
          mcheck("b_rd_addr", 128'(b_rd_addr), 128'(exp_b[b_ptr]));
          b_ptr++;
        end else mcheck("b_rd_extra", 128'(b_rd_en), 128'(0));
      end
      if (c_wr_en) begin
        log_ca.push_back(int'(c_wr_addr));
        log_cd.push_back(c_wr_data);
        if (c_ptr < exp_ca.size()) begin
          mcheck("c_wr_addr", 128'(c_wr_addr), 128'(exp_ca[c_ptr]));
          mcheck("c_wr_data", 128'(c_wr_data), 128'(exp_cd[c_ptr]));
          c_ptr++;
        end else mcheck("c_wr_extra", 128'(c_wr_en), 128'(0));
      end
      if (core_start) starts_seen++;
      if (done) dones++;
      nxt = active_q;
      if (done) nxt = 1'b0;
      if (cfg_valid && cfg_ready) nxt = 1'b1;
      if (!rst_n) nxt = 1'b0;
      active_q = nxt;
    end
  end

  task automatic run_job(input int m, input int n, input int k);
    int s0, d0;
    bit seen;
    kcur = k; ncur = n;
    build_expect(m, n, k, 1'b0);
    s0 = starts_seen; d0 = dones;
    @(posedge clk); #1;
    cfg_m_tiles = DIMW'(m); cfg_n_tiles = DIMW'(n); cfg_k_tiles = DIMW'(k);
    cfg_valid = 1'b1;
    repeat (7) @(posedge clk);
    #1 cfg_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    tcheck("done_seen", 128'(done), 128'(1));
    repeat (3) @(negedge clk);
    tcheck("core_starts", 128'(starts_seen - s0), 128'(m*n*k));
    tcheck("done_pulses", 128'(dones - d0), 128'(1));
    tcheck("a_reads_all", 128'(a_ptr), 128'(exp_a.size()));
    tcheck("b_reads_all", 128'(b_ptr), 128'(exp_b.size()));
    tcheck("c_writes_all", 128'(c_ptr), 128'(exp_ca.size()));
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        Am[i][j] = 0;
        Bm[i][j] = 0;
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a0, d0, s0;
    int lit_a2[8];
    int lit_c3[16];
    bit seen;
    lit_a2 = '{0, 2, 4, 6, 1, 3, 5, 7};
    lit_c3 = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};
    stub_v[0] = 0; stub_v[1] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    tcheck("rst_cfg_ready", 128'(cfg_ready), 128'(1));
    tcheck("rst_busy", 128'(busy), 128'(0));
    tcheck("rst_done", 128'(done), 128'(0));
    tcheck("rst_strobes", 128'({a_rd_en, b_rd_en, c_wr_en, core_start}), 128'(0));
    tcheck("rst_core_A", 128'(core_A), 128'(0));
    tcheck("rst_core_B", 128'(core_B), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // 1x1x1: identity A, B = 1..16
    clear_mats();
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        Am[i][j] = (i == j) ? 1 : 0;
        Bm[i][j] = i*T + j + 1;
      end
    c0 = log_ca.size();
    run_job(1, 1, 1);
    for (int r = 0; r < T; r++) tcheck("t1_addr", 128'(log_ca[c0 + r]), 128'(r));
    tcheck("t1_row0", 128'(log_cd[c0]), 128'({32'd4, 32'd3, 32'd2, 32'd1}));
    tcheck("t1_row3", 128'(log_cd[c0 + 3]), 128'({32'd16, 32'd15, 32'd14, 32'd13}));

    // 1x1x2: A all 1, B all 2
    clear_mats();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        Am[i][j] = 1;
        Bm[i][j] = 2;
      end
    c0 = log_ca.size(); a0 = log_a.size();
    run_job(1, 1, 2);
    for (int i = 0; i < 8; i++) tcheck("t2_a_addr", 128'(log_a[a0 + i]), 128'(lit_a2[i]));
    for (int r = 0; r < T; r++) tcheck("t2_row", 128'(log_cd[c0 + r]), 128'({4{32'd16}}));

    // 2x2x1 with mixed-sign operands
    clear_mats();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        Am[i][j] = ((i*3 + j) % 7) - 3;
        Bm[i][j] = ((i + 2*j) % 5) - 2;
      end
    c0 = log_ca.size();
    run_job(2, 2, 1);
    for (int i = 0; i < 16; i++) tcheck("t3_wr_order", 128'(log_ca[c0 + i]), 128'(lit_c3[i]));

    // k_tiles = 0: immediate completion
    d0 = dones; s0 = starts_seen;
    @(posedge clk); #1;
    cfg_m_tiles = 8'd1; cfg_n_tiles = 8'd1; cfg_k_tiles = 8'd0; cfg_valid = 1'b1;
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(negedge clk);
    tcheck("k0_done", 128'(done), 128'(1));
    tcheck("k0_busy", 128'(busy), 128'(1));
    @(negedge clk);
    tcheck("k0_done_drop", 128'(done), 128'(0));
    tcheck("k0_ready", 128'(cfg_ready), 128'(1));
    tcheck("k0_starts", 128'(starts_seen - s0), 128'(0));
    tcheck("k0_dones", 128'(dones - d0), 128'(1));

    // Accumulator wrap with stub core
    clear_mats();
    stub_mode = 1'b1;
    stub_v[0] = 32'h7FFF_FFFF; stub_v[1] = 32'h0000_0001;
    stub_base = core_starts;
    c0 = log_ca.size();
    run_job(1, 1, 2);
    for (int r = 0; r < T; r++) tcheck("wrap_row", 128'(log_cd[c0 + r]), 128'({4{32'h8000_0000}}));
    stub_mode = 1'b0;

    // Reset during WAIT, then a stale core_done
    core_auto = 1'b0;
    kcur = 1; ncur = 1;
    build_expect(1, 1, 1, 1'b1);
    s0 = starts_seen; d0 = dones;
    @(posedge clk); #1;
    cfg_m_tiles = 8'd1; cfg_n_tiles = 8'd1; cfg_k_tiles = 8'd1; cfg_valid = 1'b1;
    @(posedge clk); #1 cfg_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (starts_seen > s0) seen = 1'b1;
    end
    tcheck("rs_start_seen", 128'(starts_seen - s0), 128'(1));
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    tcheck("rs_strobes", 128'({a_rd_en, b_rd_en, c_wr_en, core_start, done, busy}), 128'(0));
    tcheck("rs_ready", 128'(cfg_ready), 128'(1));
    tcheck("rs_core_A", 128'(core_A), 128'(0));
    tcheck("rs_core_B", 128'(core_B), 128'(0));
    tcheck("rs_addr", 128'({a_rd_addr, b_rd_addr, c_wr_addr}), 128'(0));
    tcheck("rs_wdata", 128'(c_wr_data), 128'(0));
    @(posedge clk);
    @(posedge clk); #1 man_done = 1'b1;
    @(posedge clk); #1 man_done = 1'b0;
    repeat (10) @(negedge clk);
    tcheck("rs_no_done", 128'(dones - d0), 128'(0));
    tcheck("rs_no_write", 128'(c_ptr), 128'(exp_ca.size()));
    tcheck("rs_ready_after", 128'(cfg_ready), 128'(1));
    core_auto = 1'b1;

    $display("%0d/%0d checks passed", mon_pass + tb_pass, mon_total + tb_total);
    $finish;
  end

endmodule
